mem_access_stage: RTL

Pipeline MEM stage that sits directly downstream of the execute stage and upstream of writeback. It takes the registered execute result (ALU value or effective address), opcode and store data. It runs byte/half/word loads and stores over a req/ack data-memory port and stalls the pipeline while a transfer is outstanding. It presents a registered, one-cycle-per-instruction result to writeback.

---
 rtl/mem_access_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs byte/half/word loads and stores over a req/ack
// data-memory port, stalls upstream while a transfer is outstanding.
module mem_access_stage #(
  parameter int unsigned AWIDTH = 32
) (
  input  logic              ms_i_clk,
  input  logic              ms_i_rst_n,
  input  logic              ms_i_ce,
  input  logic [5:0]        ms_i_opcode,
  input  logic [31:0]       ms_i_alu_value,
  input  logic [31:0]       ms_i_data_rt,
  input  logic [4:0]        ms_i_rd,
  input  logic              ms_i_regwrite,
  output logic              ms_o_stall,
  output logic              ms_o_d_req,
  output logic              ms_o_d_we,
  output logic [3:0]        ms_o_d_be,
  output logic [AWIDTH-1:0] ms_o_d_addr,
  output logic [31:0]       ms_o_d_wdata,
  input  logic              ms_i_d_ack,
  input  logic [31:0]       ms_i_d_rdata,
  output logic              ms_o_ce,
  output logic [31:0]       ms_o_data,
  output logic [4:0]        ms_o_rd,
  output logic              ms_o_regwrite,
  output logic              ms_o_misalign
);

  localparam int unsigned DWIDTH       = 32;
  localparam int unsigned OPCODE_WIDTH = 6;

  localparam logic [OPCODE_WIDTH-1:0] OP_LB  = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_LH  = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW  = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_LBU = 6'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_LHU = 6'h25;
  localparam logic [OPCODE_WIDTH-1:0] OP_SB  = 6'h28;
  localparam logic [OPCODE_WIDTH-1:0] OP_SH  = 6'h29;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW  = 6'h2B;

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t r_state, w_state_d;

  logic                    r_req, w_req_d;
  logic                    r_we, w_we_d;
  logic [3:0]              r_be, w_be_d;
  logic [AWIDTH-1:0]       r_addr, w_addr_d;
  logic [DWIDTH-1:0]       r_wdata, w_wdata_d;
  logic                    r_ce, w_ce_d;
  logic [DWIDTH-1:0]       r_data, w_data_d;
  logic [4:0]              r_rd, w_rd_d;
  logic                    r_regwrite, w_regwrite_d;
  logic                    r_misalign, w_misalign_d;
  logic [OPCODE_WIDTH-1:0] r_op, w_op_d;
  logic [1:0]              r_off, w_off_d;
  logic [4:0]              r_cap_rd, w_cap_rd_d;
  logic                    r_cap_rw, w_cap_rw_d;

  // Decode of the incoming instruction
  logic              w_is_load, w_is_store, w_is_mem, w_is_half, w_is_word;
  logic              w_misalign, w_go_bus;
  logic [3:0]        w_be;
  logic [DWIDTH-1:0] w_wdata;

  always_comb begin
    w_is_load  = (ms_i_opcode == OP_LB) || (ms_i_opcode == OP_LH) ||
                 (ms_i_opcode == OP_LW) || (ms_i_opcode == OP_LBU) ||
                 (ms_i_opcode == OP_LHU);
    w_is_store = (ms_i_opcode == OP_SB) || (ms_i_opcode == OP_SH) ||
                 (ms_i_opcode == OP_SW);
    w_is_mem   = w_is_load || w_is_store;
    w_is_half  = (ms_i_opcode == OP_LH) || (ms_i_opcode == OP_LHU) ||
                 (ms_i_opcode == OP_SH);
    w_is_word  = (ms_i_opcode == OP_LW) || (ms_i_opcode == OP_SW);
    w_misalign = (w_is_half && ms_i_alu_value[0]) ||
                 (w_is_word && (ms_i_alu_value[1:0] != 2'b00));
    w_go_bus   = ms_i_ce && w_is_mem && !w_misalign;
    if (w_is_word) begin
      w_be    = 4'b1111;
      w_wdata = ms_i_data_rt;
    end else if (w_is_half) begin
      w_be    = ms_i_alu_value[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{ms_i_data_rt[15:0]}};
    end else begin
      w_be    = 4'(4'b0001 << ms_i_alu_value[1:0]);
      w_wdata = {4{ms_i_data_rt[7:0]}};
    end
  end

  // Lane extraction and extension of the returned load word
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [DWIDTH-1:0] w_load;

  always_comb begin
    w_lane_b = ms_i_d_rdata[{r_off, 3'b000} +: 8];
    w_lane_h = r_off[1] ? ms_i_d_rdata[31:16] : ms_i_d_rdata[15:0];
    case (r_op)
      OP_LB:   w_load = {{24{w_lane_b[7]}}, w_lane_b};
      OP_LBU:  w_load = {24'h0, w_lane_b};
      OP_LH:   w_load = {{16{w_lane_h[15]}}, w_lane_h};
      OP_LHU:  w_load = {16'h0, w_lane_h};
      default: w_load = ms_i_d_rdata;
    endcase
  end

  always_ff @(posedge ms_i_clk or negedge ms_i_rst_n) begin
    if (!ms_i_rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ce       <= 1'b0;
      r_data     <= '0;
      r_rd       <= 5'h0;
      r_regwrite <= 1'b0;
      r_misalign <= 1'b0;
      r_op       <= '0;
      r_off      <= 2'b00;
      r_cap_rd   <= 5'h0;
      r_cap_rw   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_req      <= w_req_d;
      r_we       <= w_we_d;
      r_be       <= w_be_d;
      r_addr     <= w_addr_d;
      r_wdata    <= w_wdata_d;
      r_ce       <= w_ce_d;
      r_data     <= w_data_d;
      r_rd       <= w_rd_d;
      r_regwrite <= w_regwrite_d;
      r_misalign <= w_misalign_d;
      r_op       <= w_op_d;
      r_off      <= w_off_d;
      r_cap_rd   <= w_cap_rd_d;
      r_cap_rw   <= w_cap_rw_d;
    end
  end

  // Next-state and next-output logic; everything holds unless changed below
  always_comb begin
    w_state_d    = r_state;
    w_req_d      = r_req;
    w_we_d       = r_we;
    w_be_d       = r_be;
    w_addr_d     = r_addr;
    w_wdata_d    = r_wdata;
    w_ce_d       = 1'b0;
    w_data_d     = r_data;
    w_rd_d       = r_rd;
    w_regwrite_d = r_regwrite;
    w_misalign_d = r_misalign;
    w_op_d       = r_op;
    w_off_d      = r_off;
    w_cap_rd_d   = r_cap_rd;
    w_cap_rw_d   = r_cap_rw;
    ms_o_stall   = 1'b0;

    case (r_state)
      S_IDLE: begin
        ms_o_stall = w_go_bus;
        if (ms_i_ce) begin
          if (!w_is_mem) begin
            w_ce_d       = 1'b1;
            w_data_d     = ms_i_alu_value;
            w_rd_d       = ms_i_rd;
            w_regwrite_d = ms_i_regwrite;
            w_misalign_d = 1'b0;
          end else if (w_misalign) begin
            w_ce_d       = 1'b1;
            w_data_d     = ms_i_alu_value;
            w_rd_d       = ms_i_rd;
            w_regwrite_d = 1'b0;
            w_misalign_d = 1'b1;
          end else begin
            w_op_d     = ms_i_opcode;
            w_off_d    = ms_i_alu_value[1:0];
            w_cap_rd_d = ms_i_rd;
            w_cap_rw_d = ms_i_regwrite;
            w_req_d    = 1'b1;
            w_addr_d   = {ms_i_alu_value[AWIDTH-1:2], 2'b00};
            w_we_d     = w_is_store;
            w_be_d     = w_be;
            w_wdata_d  = w_wdata;
            w_state_d  = S_BUS;
          end
        end
      end
      S_BUS: begin
        ms_o_stall = !ms_i_d_ack;
        if (ms_i_d_ack) begin
          w_req_d      = 1'b0;
          w_state_d    = S_IDLE;
          w_ce_d       = 1'b1;
          w_rd_d       = r_cap_rd;
          w_misalign_d = 1'b0;
          if (r_we) begin
            w_regwrite_d = 1'b0;
            w_data_d     = '0;
          end else begin
            w_regwrite_d = r_cap_rw;
            w_data_d     = w_load;
          end
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end

  assign ms_o_d_req    = r_req;
  assign ms_o_d_we     = r_we;
  assign ms_o_d_be     = r_be;
  assign ms_o_d_addr   = r_addr;
  assign ms_o_d_wdata  = r_wdata;
  assign ms_o_ce       = r_ce;
  assign ms_o_data     = r_data;
  assign ms_o_rd       = r_rd;
  assign ms_o_regwrite = r_regwrite;
  assign ms_o_misalign = r_misalign;

endmodule
